modulo_alimentador_rolhas: RTL
==============================

// Module: modulo_alimentador_rolhas
// PURPOSE
//  Cork feeder for the filling/capping line. Operator cork loads (already validated,
//  0..99) are accepted into a reserve register. Reserve corks are moved one per clock
//  into the principal cork buffer whenever that buffer drops below the minimum. The
//  principal buffer is drained one cork per capping event (ve & cq) and drives the
//  ro / min_signal flags used by the filling FSM and the display encoders.
// PARAMETERS
//  CAP_PRINCIPAL  40  principal buffer capacity (1..99)
//  MIN_ROLHAS     5   refill threshold; transfer starts when principal < MIN_ROLHAS (1..CAP_PRINCIPAL)
//  LOTE           15  max corks moved per transfer burst (1..99)
//  MAX_RESERVA    99  reserve saturation value (<=99)
// PORTS
//  clk            in   1  system clock (divided clock domain)
//  clr            in   1  synchronous active-high reset
//  load_valid     in   1  operator load request, sampled each clk
//  load_qty       in   7  corks to add to reserve (0..99)
//  load_ready     out  1  load accepted this cycle when load_valid & load_ready
//  consume        in   1  capping event, one cork per cycle high
//  consume_ack    out  1  registered: a cork was removed on the previous edge
//  reg_principal  out  7  principal buffer count
//  reg_reserva    out  7  reserve count
//  ro             out  1  reg_principal == 0
//  min_signal     out  1  reg_principal < MIN_ROLHAS
//  transfer_busy  out  1  FSM in TRANSFER
//  err_overflow   out  1  sticky: a load saturated the reserve
// BEHAVIOUR
//  Interface: one clock, clk; reset clr is synchronous and active-high.
//  Reset: state=IDLE, reg_principal=0, reg_reserva=0, moved=0, consume_ack=0,
//   err_overflow=0. Hence ro=1, min_signal=1, transfer_busy=0 after reset.
//  clr at any time, including mid-transfer, wins over every other input.
//  All counters are 7-bit unsigned and never exceed 99. ro, min_signal, transfer_busy
//   and load_ready are combinational from registered state.
//  start = (state==IDLE) & (reg_principal<MIN_ROLHAS) & (reg_reserva!=0).
//  load_ready = (state==IDLE) & !start. A start has priority over a load.
//  Load (load_valid & load_ready): reg_reserva <= min(reg_reserva+load_qty, MAX_RESERVA),
//   using an 8-bit sum. If the sum exceeds MAX_RESERVA, err_overflow <= 1 (held until clr).
//   load_qty=0 is accepted as a no-op.
//  Consume: evaluated in every state. If consume & reg_principal!=0, one cork is removed
//   and consume_ack<=1 for exactly 1 cycle. Otherwise nothing is removed and consume_ack<=0.
//  FSM:
//   IDLE -> TRANSFER on start; moved<=0.
//   TRANSFER each edge: step = (reg_reserva!=0) & (reg_principal<CAP_PRINCIPAL) & (moved<LOTE).
//    On step: reg_reserva-1, moved+1, principal +1 (net with consume).
//   TRANSFER -> IDLE when, after this edge, moved==LOTE or reserve==0 or principal==CAP_PRINCIPAL.
//    The move on that edge still completes. No load is accepted in the exit cycle.
//  Simultaneous step and consume: principal unchanged, reserve -1, consume_ack=1.
//   Consume with principal==0 and step in the same cycle: only the step applies (principal=1).
//  Latency: every accepted event is visible on the outputs one edge later.
//   A burst of N corks takes N cycles plus 1 entry cycle.
//  A new burst may start on the cycle after exit if the start condition still holds.
// TESTING
//  1 clr; load_qty=30 one cycle -> reserve=30. Next cycle start fires; after 16 edges principal=15,
//    reserve=15, busy 0.
//  2 principal=4, reserve=3, LOTE=15 -> burst stops at reserve=0, principal=7, FSM IDLE,
//    no restart while reserve=0.
//  3 reserve=95, load 10 -> reserve=99, err_overflow=1 until clr; subsequent load 0 keeps 99.
//  4 consume held high during a burst -> principal constant each step, reserve -1/cycle,
//    consume_ack=1 every cycle.
//  5 principal=0, reserve=0, consume pulse -> no change, consume_ack=0, ro=1.
//  6 clr asserted mid-burst (moved=7) -> next edge all zero, IDLE, load_ready=1.

Source files
------------

// File: rtl/modulo_alimentador_rolhas_if.sv
// Operator-load / capping-event / status bundle for the cork feeder.
interface modulo_alimentador_rolhas_if;
  logic       load_valid;
  logic [6:0] load_qty;
  logic       load_ready;
  logic       consume;
  logic       consume_ack;
  logic [6:0] reg_principal;
  logic [6:0] reg_reserva;
  logic       ro;
  logic       min_signal;
  logic       transfer_busy;
  logic       err_overflow;

  modport master (
    output load_valid, load_qty, consume,
    input  load_ready, consume_ack, reg_principal, reg_reserva,
           ro, min_signal, transfer_busy, err_overflow
  );

  modport slave (
    input  load_valid, load_qty, consume,
    output load_ready, consume_ack, reg_principal, reg_reserva,
           ro, min_signal, transfer_busy, err_overflow
  );
endinterface

// File: rtl/modulo_alimentador_rolhas.sv
// Cork feeder: operator loads fill a reserve, bursts move reserve corks into the
// principal buffer when it runs low, capping events drain the principal buffer.
module modulo_alimentador_rolhas #(
  parameter int unsigned CAP_PRINCIPAL = 40,
  parameter int unsigned MIN_ROLHAS    = 5,
  parameter int unsigned LOTE          = 15,
  parameter int unsigned MAX_RESERVA   = 99
) (
  input  logic                         clk,
  input  logic                         clr,
  modulo_alimentador_rolhas_if.slave   bus
);

  localparam logic [6:0] CAP_C = 7'(CAP_PRINCIPAL);
  localparam logic [6:0] MIN_C = 7'(MIN_ROLHAS);
  localparam logic [6:0] LOT_C = 7'(LOTE);
  localparam logic [6:0] MAX_C = 7'(MAX_RESERVA);

  typedef enum logic {IDLE, TRANSFER} state_t;

  function automatic logic [7:0] sum_reserva(input logic [6:0] a, input logic [6:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [6:0] sat_reserva(input logic [7:0] s);
    return (s > {1'b0, MAX_C}) ? MAX_C : s[6:0];
  endfunction

  state_t     state_q, state_d;
  logic [6:0] principal_q, principal_d;
  logic [6:0] reserva_q, reserva_d;
  logic [6:0] moved_q, moved_d;
  logic       ack_q, ack_d;
  logic       ovf_q, ovf_d;

  logic       start;
  logic       load_ready;
  logic       load_fire;
  logic       step;
  logic       take;
  logic [7:0] load_sum;

  assign start      = (state_q == IDLE) && (principal_q < MIN_C) && (reserva_q != 7'd0);
  assign load_ready = (state_q == IDLE) && !start;
  assign load_fire  = bus.load_valid && load_ready;
  assign load_sum   = sum_reserva(reserva_q, bus.load_qty);
  assign take       = bus.consume && (principal_q != 7'd0);
  assign step       = (state_q == TRANSFER) && (reserva_q != 7'd0) &&
                      (principal_q < CAP_C) && (moved_q < LOT_C);

  always_comb begin
    state_d     = state_q;
    principal_d = principal_q;
    reserva_d   = reserva_q;
    moved_d     = moved_q;
    ack_d       = take;
    ovf_d       = ovf_q;

    // A step and a removal in the same cycle cancel on the principal buffer.
    unique case ({step, take})
      2'b10:   principal_d = principal_q + 7'd1;
      2'b01:   principal_d = principal_q - 7'd1;
      default: principal_d = principal_q;
    endcase

    if (load_fire) begin
      reserva_d = sat_reserva(load_sum);
      if (load_sum > {1'b0, MAX_C}) ovf_d = 1'b1;
    end else if (step) begin
      reserva_d = reserva_q - 7'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TRANSFER;
          moved_d = 7'd0;
        end
      end
      TRANSFER: begin
        if (step) moved_d = moved_q + 7'd1;
        // Exit decision looks at the post-edge values so the final move still lands.
        if ((moved_d == LOT_C) || (reserva_d == 7'd0) || (principal_d == CAP_C))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      principal_q <= 7'd0;
      reserva_q   <= 7'd0;
      moved_q     <= 7'd0;
      ack_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      principal_q <= principal_d;
      reserva_q   <= reserva_d;
      moved_q     <= moved_d;
      ack_q       <= ack_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.load_ready    = load_ready;
  assign bus.consume_ack   = ack_q;
  assign bus.reg_principal = principal_q;
  assign bus.reg_reserva   = reserva_q;
  assign bus.ro            = (principal_q == 7'd0);
  assign bus.min_signal    = (principal_q < MIN_C);
  assign bus.transfer_busy = (state_q == TRANSFER);
  assign bus.err_overflow  = ovf_q;

endmodule
